// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light PWM decoder: light classes, FSM states
// and the nominal PWM period of the transmitting driver.
package traffic_pkg;

    localparam int DEFAULT_PWM_PERIOD = 100;
    localparam int CNT_W              = 8;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        MEASURE = 2'b01,
        LOCKED  = 2'b10
    } fsm_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM line plus rising-edge detect
// on the synchronized level.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic level_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            level_p2 <= 1'b0;
        end else begin
            sync_p0  <= pwm_in;
            sync_p1  <= sync_p0;
            level_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~level_p2;

endmodule

// File: rtl/pwm_decoder.sv
// Decodes the traffic-light PWM line into RED/GREEN/YELLOW by measuring the
// period and high time between rising edges, with confirmation and timeout.
module pwm_decoder
    import traffic_pkg::*;
#(
    parameter int PWM_PERIOD  = DEFAULT_PWM_PERIOD,
    parameter int PERIOD_TOL  = 5,
    parameter int RED_MAX     = 30,
    parameter int GREEN_MIN   = 70,
    parameter int TIMEOUT_CYC = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [1:0] traffic_state,
    output logic       state_valid,
    output logic       state_change,
    output logic       period_err,
    output logic       timeout
);

    localparam logic signed [9:0] NOM_S       = 10'(PWM_PERIOD);
    localparam logic signed [9:0] TOL_S       = 10'(PERIOD_TOL);
    localparam logic [CNT_W-1:0]  RED_MAX_C   = CNT_W'(RED_MAX);
    localparam logic [CNT_W-1:0]  GREEN_MIN_C = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT_CYC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] sat_conf(input logic [1:0] v);
        return (v == 2'd2) ? v : v + 2'd1;
    endfunction

    function automatic logic period_ok(input logic [CNT_W-1:0] p);
        logic signed [9:0] dev;
        dev = $signed({2'b00, p}) - NOM_S;
        return (dev <= TOL_S) && (dev >= -TOL_S);
    endfunction

    function automatic light_t classify(input logic [CNT_W-1:0] h);
        if (h <= RED_MAX_C)   return RED;
        if (h >= GREEN_MIN_C) return GREEN;
        return YELLOW;
    endfunction

    logic             level;
    logic             rise;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    fsm_t             fsm;
    light_t           cand;
    light_t           cls;
    logic [1:0]       conf_cnt;
    logic [1:0]       conf_next;
    logic             confirm;
    logic             state_known;

    pwm_edge_sync u_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise)
    );

    // Capture stage: counters sampled on the edge-detect cycle feed classification
    always_comb begin
        cls       = classify(high_cnt);
        conf_next = (conf_cnt != 2'd0 && cls == cand) ? sat_conf(conf_cnt) : 2'd1;
        confirm   = (conf_next == 2'd2);
    end

    // Decision stage: all outputs registered one cycle after the capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm           <= SEARCH;
            period_cnt    <= '0;
            high_cnt      <= '0;
            cand          <= RED;
            conf_cnt      <= 2'd0;
            state_known   <= 1'b0;
            traffic_state <= RED;
            state_valid   <= 1'b0;
            state_change  <= 1'b0;
            period_err    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state_change <= 1'b0;
            period_err   <= 1'b0;
            timeout      <= 1'b0;

            period_cnt <= rise ? CNT_W'(1) : sat_inc(period_cnt);
            high_cnt   <= rise ? CNT_W'(1) : (level ? sat_inc(high_cnt) : high_cnt);

            case (fsm)
                SEARCH: begin
                    if (rise) begin
                        fsm      <= MEASURE;
                        conf_cnt <= 2'd0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        if (!period_ok(period_cnt)) begin
                            period_err <= 1'b1;
                            conf_cnt   <= 2'd0;
                            if (fsm == LOCKED) begin
                                fsm         <= MEASURE;
                                state_valid <= 1'b0;
                            end
                        end else begin
                            cand     <= cls;
                            conf_cnt <= conf_next;
                            if (confirm && (fsm == MEASURE || cls != traffic_state)) begin
                                // First lock after reset always announces itself
                                if (!state_known || cls != traffic_state)
                                    state_change <= 1'b1;
                                traffic_state <= cls;
                                state_valid   <= 1'b1;
                                state_known   <= 1'b1;
                                fsm           <= LOCKED;
                            end
                        end
                    end else if (period_cnt == TIMEOUT_C) begin
                        timeout     <= 1'b1;
                        fsm         <= SEARCH;
                        state_valid <= 1'b0;
                        conf_cnt    <= 2'd0;
                    end
                end
                default: fsm <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Randomized bench for pwm_decoder: a pin-level event model predicts every
// output each cycle, plus directed lock/switch/error/timeout/reset scenarios.
module tb_pwm_decoder;

    localparam int P_NOM = 100;
    localparam int P_TOL = 5;
    localparam int T_OUT = 250;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [1:0] traffic_state;
    logic       state_valid;
    logic       state_change;
    logic       period_err;
    logic       timeout;

    pwm_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pwm_in        (pwm_in),
        .traffic_state (traffic_state),
        .state_valid   (state_valid),
        .state_change  (state_change),
        .period_err    (period_err),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       vld;
        logic       chg;
        logic       perr;
        logic       tmo;
    } obs_t;

    obs_t pend[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    bit   m_active, m_locked, m_valid, m_known, m_prev;
    int   m_state, m_last_rise, m_high;
    int   m_hist[$];

    int   n_chg, n_perr, n_tmo, n_vld_low, n_vld_high, vrise_step, tmo_step, s_start;
    bit   prev_vld;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @step %0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int class_of(input int h);
        if (h <= 30) return 0;
        if (h >= 70) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_valid = 0; m_known = 0; m_prev = 0;
        m_state = 0; m_last_rise = 0; m_high = 0;
        m_hist.delete();
        pend.delete();
        pend.push_back('0);
        pend.push_back('0);
    endtask

    // Pin-domain model: effects of pin step cyc appear at the outputs two steps later
    task automatic model_step(input logic v, output obs_t o);
        int period;
        int c;
        o = '0;
        if (v && !m_prev) begin
            if (!m_active) begin
                m_active = 1;
                m_hist.delete();
            end else begin
                period = cyc - m_last_rise;
                if (period > P_NOM + P_TOL || period < P_NOM - P_TOL) begin
                    o.perr = 1'b1;
                    m_hist.delete();
                    if (m_locked) begin
                        m_locked = 0;
                        m_valid  = 0;
                    end
                end else begin
                    c = class_of(m_high);
                    m_hist.push_back(c);
                    if (m_hist.size() >= 2 && m_hist[m_hist.size()-1] == m_hist[m_hist.size()-2]
                        && (!m_locked || c != m_state)) begin
                        if (!m_known || c != m_state) o.chg = 1'b1;
                        m_state = c; m_valid = 1; m_locked = 1; m_known = 1;
                    end
                end
            end
            m_last_rise = cyc;
            m_high = 1;
        end else begin
            if (v) m_high++;
            if (m_active && cyc - m_last_rise == T_OUT) begin
                o.tmo = 1'b1;
                m_active = 0; m_locked = 0; m_valid = 0;
                m_hist.delete();
            end
        end
        m_prev = v;
        o.st  = 2'(m_state);
        o.vld = m_valid;
    endtask

    task automatic step(input logic v);
        obs_t o;
        obs_t e;
        pwm_in = v;
        @(posedge clk);
        #1;
        cyc++;
        model_step(v, o);
        pend.push_back(o);
        e = pend.pop_front();
        check_eq("traffic_state", traffic_state, e.st);
        check_eq("state_valid", state_valid, e.vld);
        check_eq("state_change", state_change, e.chg);
        check_eq("period_err", period_err, e.perr);
        check_eq("timeout", timeout, e.tmo);
        if (state_change) n_chg++;
        if (period_err) n_perr++;
        if (timeout) begin n_tmo++; tmo_step = cyc; end
        if (state_valid && !prev_vld) vrise_step = cyc;
        if (state_valid) n_vld_high++; else n_vld_low++;
        prev_vld = state_valid;
    endtask

    task automatic reset_step();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
        check_eq("rst_traffic_state", traffic_state, 0);
        check_eq("rst_state_valid", state_valid, 0);
        check_eq("rst_state_change", state_change, 0);
        check_eq("rst_period_err", period_err, 0);
        check_eq("rst_timeout", timeout, 0);
        prev_vld = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic drive_period(input int h, input int p);
        for (int i = 0; i < p; i++) step(i < h);
    endtask

    task automatic clear_counts();
        n_chg = 0; n_perr = 0; n_tmo = 0; n_vld_low = 0; n_vld_high = 0;
        vrise_step = -1; tmo_step = -1;
    endtask

    task automatic random_segment();
        int kind;
        int reps;
        int h;
        int p;
        int duty_tbl[10] = '{1, 10, 29, 30, 31, 50, 69, 70, 71, 90};
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            drive_level(0, $urandom_range(235, 265));
        end else if (kind == 1) begin
            drive_level(0, $urandom_range(5, 20));
            reset_step();
            drive_level(0, $urandom_range(1, 5));
        end else begin
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 89) : duty_tbl[$urandom_range(0, 9)];
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                p = ($urandom_range(0, 3) == 0) ? P_NOM + $urandom_range(0, 20) - 10 : P_NOM;
                drive_period(h, p);
            end
        end
    endtask

    initial begin
        clear_counts();
        prev_vld = 1'b0;
        repeat (3) reset_step();
        drive_level(0, 5);

        // Lock onto RED from a clean start
        clear_counts();
        s_start = cyc + 1;
        repeat (4) drive_period(10, 100);
        check_eq("lock_red_change_cnt", n_chg, 1);
        check_eq("lock_red_state", traffic_state, 0);
        check_eq("lock_red_valid", state_valid, 1);
        check_eq("lock_red_latency", vrise_step - s_start, 202);

        // RED -> GREEN while locked
        clear_counts();
        repeat (3) drive_period(90, 100);
        check_eq("switch_green_change_cnt", n_chg, 1);
        check_eq("switch_green_state", traffic_state, 1);
        check_eq("switch_green_valid_drop", n_vld_low, 0);

        // One 110-cycle period while locked
        clear_counts();
        drive_period(90, 110);
        repeat (3) drive_period(90, 100);
        check_eq("bad_period_err_cnt", n_perr, 1);
        check_eq("bad_period_valid_dropped", n_vld_low != 0, 1);
        check_eq("bad_period_change_cnt", n_chg, 0);
        check_eq("bad_period_state_held", traffic_state, 1);
        check_eq("bad_period_relock", state_valid, 1);

        // Line stuck low after an edge
        clear_counts();
        s_start = cyc + 1;
        drive_level(1, 90);
        drive_level(0, 300);
        check_eq("stuck_timeout_cnt", n_tmo, 1);
        check_eq("stuck_timeout_latency", tmo_step - s_start, 252);
        check_eq("stuck_valid", state_valid, 0);

        // Alternating 50/90 never confirms, then class boundaries
        clear_counts();
        repeat (8) begin
            drive_period(50, 100);
            drive_period(90, 100);
        end
        check_eq("alt_valid_cycles", n_vld_high, 0);
        check_eq("alt_change_cnt", n_chg, 0);
        repeat (3) drive_period(30, 100);
        check_eq("high30_state", traffic_state, 0);
        check_eq("high30_valid", state_valid, 1);
        repeat (3) drive_period(31, 100);
        check_eq("high31_state", traffic_state, 2);
        repeat (3) drive_period(70, 100);
        check_eq("high70_state", traffic_state, 1);
        repeat (3) drive_period(69, 100);
        check_eq("high69_state", traffic_state, 2);

        // Reset pulse mid-period while locked, then relock
        repeat (3) drive_period(10, 100);
        check_eq("pre_reset_state", traffic_state, 0);
        drive_level(1, 10);
        drive_level(0, 40);
        reset_step();
        drive_level(0, 50);
        clear_counts();
        s_start = cyc + 1;
        repeat (4) drive_period(10, 100);
        check_eq("relock_latency", vrise_step - s_start, 202);
        check_eq("relock_change_cnt", n_chg, 1);
        check_eq("relock_state", traffic_state, 0);

        repeat (60) random_segment();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog step=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
